// File: rtl/op_result_sel_if.sv
// Request/result bundle for op_result_sel. The producer/consumer side uses
// the master modport; the selector itself uses the slave modport.
interface op_result_sel_if #(
    parameter int N_OPS = 4,
    parameter int IN_W  = 64,
    parameter int OUT_W = 16
);
    // Request side: one-hot select over the flattened unit results
    logic [N_OPS*IN_W-1:0] op_data;
    logic [N_OPS-1:0]      op_err;
    logic [N_OPS-1:0]      op_sel;
    logic                  sel_valid;
    logic                  sel_ready;

    // Result side: registered sign/magnitude result with error reporting
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      abs_out;
    logic                  neg;
    logic                  ovf;
    logic                  err;
    logic [1:0]            err_code;

    // Sticky error flag for the control FSM
    logic                  err_sticky;
    logic                  clr_err;

    modport master (
        output op_data, op_err, op_sel, sel_valid, out_ready, clr_err,
        input  sel_ready, out_valid, abs_out, neg, ovf, err, err_code, err_sticky
    );

    modport slave (
        input  op_data, op_err, op_sel, sel_valid, out_ready, clr_err,
        output sel_ready, out_valid, abs_out, neg, ovf, err, err_code, err_sticky
    );
endinterface

// File: rtl/op_result_sel.sv
// Registered result selector between the arithmetic units and the
// display/sign stage. One request is captured per handshake, the selected
// unit result is narrowed to OUT_W (saturating or wrapping), converted to
// sign/magnitude and held under a valid/ready handshake.
module op_result_sel #(
    parameter int N_OPS = 4,
    parameter int IN_W  = 64,
    parameter int OUT_W = 16,
    parameter bit SAT   = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    op_result_sel_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SRC  = 2'd1;
    localparam logic [1:0] ERR_SEL  = 2'd2;

    // Saturation limits for the narrowed signed result
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t             state_q,  state_d;

    // Capture registers loaded on accept
    logic [N_OPS-1:0]   sel_q,    sel_d;
    logic [IN_W-1:0]    data_q,   data_d;
    logic               serr_q,   serr_d;

    // Result registers driven straight onto the outputs
    logic               valid_q,  valid_d;
    logic [OUT_W-1:0]   abs_q,    abs_d;
    logic               neg_q,    neg_d;
    logic               ovf_q,    ovf_d;
    logic               err_q,    err_d;
    logic [1:0]         code_q,   code_d;
    logic               sticky_q, sticky_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [IN_W-1:0]    chan_val;
    logic               chan_err;
    logic               sel_onehot;
    logic [IN_W-OUT_W:0] hi_bits;
    logic               narrow_ovf;
    logic [OUT_W-1:0]   narrowed;
    logic               narrow_neg;
    logic [OUT_W-1:0]   narrow_abs;
    logic               sticky_set;

    // AND-OR mux of the live request; a non-one-hot select produces junk
    // here, but that case is flagged as a bad select before it is used.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so
        // no path through the block leaves it unassigned (no latch).
        chan_val = '0;
        chan_err = 1'b0;
        for (int k = 0; k < N_OPS; k++) begin
            if (bus.op_sel[k]) begin
                chan_val = chan_val | bus.op_data[k*IN_W +: IN_W];
                chan_err = chan_err | bus.op_err[k];
            end
        end
    end

    // One-hot check on the captured select: non-zero with a single bit set
    always_comb begin
        sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
    end

    // Narrow the captured value to OUT_W and derive sign/magnitude
    always_comb begin
        // The value fits only if every bit from the OUT_W sign bit upward
        // is a copy of the same sign.
        hi_bits    = data_q[IN_W-1:OUT_W-1];
        narrow_ovf = !((&hi_bits) || (~|hi_bits));

        if (narrow_ovf && SAT) begin
            narrowed = data_q[IN_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            narrowed = data_q[OUT_W-1:0];
        end

        // The most-negative value negates to itself, which read as unsigned
        // is exactly its magnitude, so it needs no special case.
        narrow_neg = narrowed[OUT_W-1];
        narrow_abs = narrow_neg ? (-narrowed) : narrowed;
    end

    // Next-state, capture and result computation
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        data_d     = data_q;
        serr_d     = serr_q;
        valid_d    = valid_q;
        abs_d      = abs_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        code_d     = code_q;
        sticky_set = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.sel_valid) begin
                    sel_d   = bus.op_sel;
                    data_d  = chan_val;
                    serr_d  = chan_err;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                // Bad select outranks a source error; either one zeroes
                // the numeric outputs.
                if (!sel_onehot) begin
                    err_d  = 1'b1;
                    code_d = ERR_SEL;
                    abs_d  = '0;
                    neg_d  = 1'b0;
                    ovf_d  = 1'b0;
                end else if (serr_q) begin
                    err_d  = 1'b1;
                    code_d = ERR_SRC;
                    abs_d  = '0;
                    neg_d  = 1'b0;
                    ovf_d  = 1'b0;
                end else begin
                    err_d  = 1'b0;
                    code_d = ERR_NONE;
                    abs_d  = narrow_abs;
                    neg_d  = narrow_neg;
                    ovf_d  = narrow_ovf;
                end
                sticky_set = err_d;
                valid_d    = 1'b1;
                state_d    = S_OUT;
            end

            S_OUT: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky error: clear on request, but a coincident set wins
    always_comb begin
        sticky_d = sticky_q;
        if (bus.clr_err) begin
            sticky_d = 1'b0;
        end
        if (sticky_set) begin
            sticky_d = 1'b1;
        end
    end

    // State, capture and result registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            data_q   <= '0;
            serr_q   <= 1'b0;
            valid_q  <= 1'b0;
            abs_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            sticky_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its _d value from before this edge.
            state_q  <= state_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            serr_q   <= serr_d;
            valid_q  <= valid_d;
            abs_q    <= abs_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            code_q   <= code_d;
            sticky_q <= sticky_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: sel_ready is decoded from state and held low during reset;
    // everything else comes straight from registers.
    // ------------------------------------------------------------------
    assign bus.sel_ready  = (state_q == S_IDLE) && reset_n;
    assign bus.out_valid  = valid_q;
    assign bus.abs_out    = abs_q;
    assign bus.neg        = neg_q;
    assign bus.ovf        = ovf_q;
    assign bus.err        = err_q;
    assign bus.err_code   = code_q;
    assign bus.err_sticky = sticky_q;

endmodule
